mw_lsu: RTL and testbench
=========================

Name: mw_lsu

Overview:
- Load/store unit of the MW (memory/writeback) stage, directly downstream of the DE→MW pipeline register.
- Consumes the registered instruction, ALU result (effective address) and store data.
- Drives a req/gnt/rvalid data-memory port and returns formatted load data to writeback.
- Raises a stall back to the DE→MW register while an access is outstanding; flags misaligned/faulted accesses.

Parameters:
TIMEOUT_CYCLES, 64, cycles in REQ+WAIT_RSP before declaring an access fault; must be ≥2
CNT_W, 8, width of timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous reset, active-low (0 = reset)
inst_i  in  32  instruction from DE→MW register; 32'h0 = bubble
addr_i  in  32  effective address (ALU result)
wdata_i  in  32  store data (rs2)
pipe_hold_i  in  1  DE→MW register held by another source this cycle
dmem_req  out  1  access request, held until grant
dmem_we  out  1  1 = store
dmem_addr  out  32  word-aligned address {addr[31:2],2'b00}
dmem_be  out  4  byte enables
dmem_wdata  out  32  lane-replicated store data
dmem_gnt  in  1  request accepted this cycle
dmem_rvalid  in  1  load data valid
dmem_rdata  in  32  load data word
lsu_stall  out  1  hold DE→MW register and upstream
lsu_rdata  out  32  sign/zero-extended load result
lsu_rvalid  out  1  lsu_rdata valid for writeback (one cycle per load)
exc_ld_misalign  out  1  load misaligned pulse
exc_st_misalign  out  1  store misaligned pulse
exc_access_fault  out  1  timeout fault pulse
exc_illegal  out  1  reserved load/store funct3 pulse
exc_tval  out  32  faulting address, valid with any exc_* pulse

Behaviour:
- Decode: opcode 0000011 = load, 0100011 = store; funct3 {000 B, 001 H, 010 W, 100 BU, 101 HU}. Stores accept only 000/001/010. Other funct3 → exc_illegal. Non-memory opcodes and bubbles → no action.
- States: IDLE, REQ, WAIT_RSP, DONE.
- IDLE:
  - Valid aligned mem op → lsu_stall=1 combinationally; next state REQ. Capture we, be, wdata, word addr and funct3/addr[1:0] into registers.
  - Misaligned (H with addr[0]=1; W with addr[1:0]≠0) or illegal → no bus request; one-cycle exc_* pulse with exc_tval=addr_i; lsu_stall=0; stay IDLE.
- REQ:
  - dmem_req=1; outputs stable until dmem_gnt.
  - gnt & store → DONE. gnt & load → WAIT_RSP.
  - lsu_stall=1.
- WAIT_RSP:
  - dmem_req=0.
  - rvalid → register rdata, go DONE.
  - rvalid coinciding with gnt in REQ is not legal; rvalid is sampled only in WAIT_RSP.
- Timeout:
  - Counter clears on IDLE→REQ and counts every cycle in REQ/WAIT_RSP.
  - Reaching TIMEOUT_CYCLES without completion → DONE with exc_access_fault pulse, exc_tval=captured byte address, load result forced 0, dmem_req dropped.
- DONE:
  - lsu_stall=0; lsu_rvalid=1 for loads (not on fault).
  - pipe_hold_i=1 → remain DONE, lsu_rvalid held, no re-issue. Otherwise → IDLE next cycle.
- Store lanes:
  - SB: be=1<<addr[1:0], wdata={4{wdata[7:0]}}.
  - SH: be=addr[1]?1100:0011, wdata={2{wdata[15:0]}}.
  - SW: be=1111.
- Load format: select byte/half by captured addr[1:0]; B/H sign-extend, BU/HU zero-extend, W pass-through.
- Latency (zero-wait memory):
  - Load: 4 MW cycles (IDLE, REQ, WAIT_RSP, DONE), stall 3.
  - Store: 3 cycles, stall 2.
- Reset (reset=0 at edge), including mid-access: state IDLE, counter 0. All outputs 0: dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, lsu_rdata, lsu_rvalid, exc_*, exc_tval. lsu_stall=0. Any in-flight response after reset is ignored.

Decomposition:
- Package mw_lsu_pkg: opcode constants, funct3 constants, state enum.
- Sub-module mw_load_fmt: combinational rdata/funct3/offset → formatted 32-bit result.

Test Plan:
- LW addr 0x100, gnt at 1st REQ cycle, rvalid next cycle with rdata 0xDEADBEEF → dmem_addr=0x100, be=1111; lsu_rdata=0xDEADBEEF with lsu_rvalid in 4th cycle; lsu_stall high exactly 3 cycles.
- LB/LBU/LH/LHU at offsets 0..3 on rdata 0x80FF7F01 → LB@3=0xFFFFFF80, LBU@3=0x00000080, LH@2=0xFFFF80FF, LHU@0=0x00007F01.
- SB wdata 0x000000AB addr 0x203; SH wdata 0x1234 addr 0x202 → be=1000, wdata=0xABABABAB; be=1100, wdata=0x12341234; store completes 3 cycles.
- LW addr 0x102; SH addr 0x101; load funct3=011 → exc_ld_misalign / exc_st_misalign / exc_illegal one cycle each, exc_tval=addr, dmem_req never asserts.
- gnt withheld for TIMEOUT_CYCLES → exc_access_fault pulse, dmem_req drops, lsu_rvalid=0, FSM back to IDLE.
- reset=0 while in WAIT_RSP, then rvalid arrives → all outputs 0; no lsu_rvalid. pipe_hold_i=1 in DONE for 2 cycles → no second dmem_req.

Source files
------------

// File: rtl/mw_lsu_pkg.sv
// Shared constants, state type and store lane helpers for the MW-stage
// load/store unit.
package mw_lsu_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_RSP,
        S_DONE
    } state_e;

    // Byte enables for an access of size funct3[1:0] at byte offset off.
    function automatic logic [3:0] acc_be(input logic [2:0] f3,
                                          input logic [1:0] off);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] st_wdata(input logic [2:0]  f3,
                                             input logic [31:0] wd);
        logic [31:0] d;
        case (f3[1:0])
            2'b00:   d = {4{wd[7:0]}};
            2'b01:   d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mw_load_fmt.sv
// Selects the addressed byte/half of a load word and sign/zero extends it.
module mw_load_fmt
    import mw_lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    output logic [31:0] result
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = rdata[{off, 3'b000} +: 8];
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    result = {{24{b[7]}}, b};
            F3_BU:   result = {24'h0, b};
            F3_H:    result = {{16{h[15]}}, h};
            F3_HU:   result = {16'h0, h};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mw_lsu.sv
// MW-stage load/store unit: decodes the registered mem op, runs one
// req/gnt/rvalid access with timeout, and returns formatted load data.
module mw_lsu
    import mw_lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] inst_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        pipe_hold_i,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        lsu_stall,
    output logic [31:0] lsu_rdata,
    output logic        lsu_rvalid,
    output logic        exc_ld_misalign,
    output logic        exc_st_misalign,
    output logic        exc_access_fault,
    output logic        exc_illegal,
    output logic [31:0] exc_tval
);

    state_e             state_q, state_d;
    logic               we_q;
    logic [2:0]         f3_q;
    logic [31:0]        addr_q;
    logic [3:0]         be_q;
    logic [31:0]        wdata_q;
    logic [31:0]        rdata_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               fault_q;
    logic               fault_set;

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        is_ld, is_st, f3_ok_ld, f3_ok_st;
    logic        ill, mis, go, tmo;
    logic [31:0] fmt;
    logic        unused_inst;

    assign opc         = inst_i[6:0];
    assign f3          = inst_i[14:12];
    assign unused_inst = ^{inst_i[31:15], inst_i[11:7]};

    // Decode is masked during reset so no pulse escapes a reset cycle.
    assign is_ld    = reset && (opc == OP_LOAD);
    assign is_st    = reset && (opc == OP_STORE);
    assign f3_ok_ld = f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    assign f3_ok_st = f3 inside {F3_B, F3_H, F3_W};
    assign ill      = (is_ld && !f3_ok_ld) || (is_st && !f3_ok_st);
    assign mis      = (is_ld || is_st) && !ill &&
                      (((f3[1:0] == 2'b01) && addr_i[0]) ||
                       ((f3[1:0] == 2'b10) && (addr_i[1:0] != 2'b00)));
    assign go       = (is_ld || is_st) && !ill && !mis;
    assign tmo      = cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);

    always_comb begin
        state_d          = state_q;
        fault_set        = 1'b0;
        lsu_stall        = 1'b0;
        exc_ld_misalign  = 1'b0;
        exc_st_misalign  = 1'b0;
        exc_access_fault = 1'b0;
        exc_illegal      = 1'b0;
        exc_tval         = 32'h0;
        unique case (state_q)
            S_IDLE: begin
                lsu_stall       = go;
                exc_ld_misalign = mis && is_ld;
                exc_st_misalign = mis && is_st;
                exc_illegal     = ill;
                if (mis || ill) exc_tval = addr_i;
                if (go)         state_d  = S_REQ;
            end
            S_REQ: begin
                lsu_stall = 1'b1;
                if (dmem_gnt && we_q) begin
                    state_d = S_DONE;
                end else if (tmo) begin
                    state_d   = S_DONE;
                    fault_set = 1'b1;
                end else if (dmem_gnt) begin
                    state_d = S_WAIT_RSP;
                end
            end
            S_WAIT_RSP: begin
                lsu_stall = 1'b1;
                if (dmem_rvalid) begin
                    state_d = S_DONE;
                end else if (tmo) begin
                    state_d   = S_DONE;
                    fault_set = 1'b1;
                end
            end
            S_DONE: begin
                exc_access_fault = fault_q;
                if (fault_q)      exc_tval = addr_q;
                if (!pipe_hold_i) state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b0;
            addr_q  <= 32'h0;
            be_q    <= 4'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && go) begin
                we_q    <= is_st;
                f3_q    <= f3;
                addr_q  <= addr_i;
                be_q    <= acc_be(f3, addr_i[1:0]);
                wdata_q <= is_st ? st_wdata(f3, wdata_i) : 32'h0;
                cnt_q   <= '0;
                fault_q <= 1'b0;
            end
            if (state_q == S_REQ || state_q == S_WAIT_RSP)
                cnt_q <= cnt_q + CNT_W'(1);
            if (fault_set)
                fault_q <= 1'b1;
            if (state_q == S_WAIT_RSP && dmem_rvalid)
                rdata_q <= dmem_rdata;
        end
    end

    mw_load_fmt u_fmt (
        .rdata  (rdata_q),
        .funct3 (f3_q),
        .off    (addr_q[1:0]),
        .result (fmt)
    );

    assign dmem_req   = state_q == S_REQ;
    assign dmem_we    = we_q;
    assign dmem_addr  = {addr_q[31:2], 2'b00};
    assign dmem_be    = be_q;
    assign dmem_wdata = wdata_q;
    assign lsu_rvalid = (state_q == S_DONE) && !we_q && !fault_q;
    assign lsu_rdata  = lsu_rvalid ? fmt : 32'h0;

endmodule

// File: tb/tb_mw_lsu.sv
// Randomised and directed checks of mw_lsu against a cycle-timeline
// reference model of the access protocol.
module tb_mw_lsu;

    localparam int T = 16;
    localparam logic [6:0] LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011;
    localparam logic [6:0] AL = 7'b0110011;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] inst_i, addr_i, wdata_i;
    logic        pipe_hold_i;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        lsu_stall, lsu_rvalid;
    logic [31:0] lsu_rdata;
    logic        exc_ld_misalign, exc_st_misalign;
    logic        exc_access_fault, exc_illegal;
    logic [31:0] exc_tval;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mw_lsu #(.TIMEOUT_CYCLES(T), .CNT_W(8)) dut (
        .clk              (clk),
        .reset            (reset),
        .inst_i           (inst_i),
        .addr_i           (addr_i),
        .wdata_i          (wdata_i),
        .pipe_hold_i      (pipe_hold_i),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .dmem_addr        (dmem_addr),
        .dmem_be          (dmem_be),
        .dmem_wdata       (dmem_wdata),
        .dmem_gnt         (dmem_gnt),
        .dmem_rvalid      (dmem_rvalid),
        .dmem_rdata       (dmem_rdata),
        .lsu_stall        (lsu_stall),
        .lsu_rdata        (lsu_rdata),
        .lsu_rvalid       (lsu_rvalid),
        .exc_ld_misalign  (exc_ld_misalign),
        .exc_st_misalign  (exc_st_misalign),
        .exc_access_fault (exc_access_fault),
        .exc_illegal      (exc_illegal),
        .exc_tval         (exc_tval)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] op,
                                       input logic [2:0] f3);
        logic [31:0] x;
        x = $urandom;
        x[6:0] = op;
        x[14:12] = f3;
        return x;
    endfunction

    // Load result from byte arithmetic on the memory word.
    function automatic logic [31:0] ld_ref(input logic [2:0] f3,
                                           input logic [31:0] a,
                                           input logic [31:0] w);
        int nb;
        longint v, m;
        nb = 1 << f3[1:0];
        v = longint'(w >> (8 * (a % 4)));
        if (nb < 4) begin
            m = longint'(1) << (8 * nb);
            v = v % m;
            if (!f3[2] && v >= m / 2) v = v - m;
        end
        return v[31:0];
    endfunction

    function automatic logic [31:0] wd_ref(input logic [2:0] f3,
                                           input logic [31:0] d);
        if (f3[1:0] == 2'b00) return d[7:0] * 32'h01010101;
        if (f3[1:0] == 2'b01) return d[15:0] * 32'h00010001;
        return d;
    endfunction

    function automatic logic [3:0] be_ref(input logic [2:0] f3,
                                          input logic [31:0] a);
        int nb;
        int v;
        nb = 1 << f3[1:0];
        v = ((1 << nb) - 1) << (a % 4);
        return v[3:0];
    endfunction

    task automatic drive(input logic [31:0] inst, input logic [31:0] a,
                         input logic [31:0] wd, input logic hold,
                         input logic gnt, input logic rv,
                         input logic [31:0] rd);
        @(negedge clk);
        inst_i      = inst;
        addr_i      = a;
        wdata_i     = wd;
        pipe_hold_i = hold;
        dmem_gnt    = gnt;
        dmem_rvalid = rv;
        dmem_rdata  = rd;
        #1;
    endtask

    function automatic logic [3:0] exv();
        return {exc_ld_misalign, exc_st_misalign,
                exc_access_fault, exc_illegal};
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, ".req"},   {31'h0, dmem_req}, 32'h0);
        chk({tag, ".we"},    {31'h0, dmem_we}, 32'h0);
        chk({tag, ".addr"},  dmem_addr, 32'h0);
        chk({tag, ".be"},    {28'h0, dmem_be}, 32'h0);
        chk({tag, ".wd"},    dmem_wdata, 32'h0);
        chk({tag, ".rdata"}, lsu_rdata, 32'h0);
        chk({tag, ".rv"},    {31'h0, lsu_rvalid}, 32'h0);
        chk({tag, ".stall"}, {31'h0, lsu_stall}, 32'h0);
        chk({tag, ".exc"},   {28'h0, exv()}, 32'h0);
        chk({tag, ".tval"},  exc_tval, 32'h0);
    endtask

    // g: cycles gnt is withheld in REQ; r: rvalid delay after grant;
    // h: DONE cycles with pipe_hold_i asserted.
    task automatic run_op(input string tag, input logic [31:0] inst,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rd, input int g,
                          input int r, input int h);
        logic [2:0] f3;
        logic is_ld, is_st, legal, misal;
        logic [3:0] ex0;
        int c, last, done_t, total;
        logic fault;
        logic [3:0] e_ex;
        logic e_req, e_stall, e_rv, gnt, rv, hold;
        logic [31:0] ins;
        f3    = inst[14:12];
        is_ld = inst[6:0] == LD;
        is_st = inst[6:0] == ST;
        legal = is_ld ? (f3 != 3'd3 && f3 < 3'd6) : (is_st && f3 <= 3'd2);
        misal = legal && (a % (1 << f3[1:0])) != 0;
        ex0   = {is_ld && misal, is_st && misal, 1'b0,
                 (is_ld || is_st) && !legal};
        if (!legal || misal) begin
            drive(inst, a, wd, 1'b0, 1'b0, 1'b0, rd);
            chk({tag, ".exc"},   {28'h0, exv()}, {28'h0, ex0});
            chk({tag, ".stall"}, {31'h0, lsu_stall}, 32'h0);
            chk({tag, ".req"},   {31'h0, dmem_req}, 32'h0);
            if (ex0 != 4'h0) chk({tag, ".tval"}, exc_tval, a);
            drive(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
            chk({tag, ".req1"}, {31'h0, dmem_req}, 32'h0);
            chk({tag, ".exc1"}, {28'h0, exv()}, 32'h0);
            return;
        end
        c      = is_ld ? g + 1 + r : g;
        fault  = c > T - 1;
        last   = fault ? T - 1 : c;
        done_t = last + 2;
        total  = done_t + h + 1;
        for (int t = 0; t <= total; t++) begin
            ins  = (t < total) ? inst : 32'h0;
            hold = t >= done_t && t < done_t + h;
            gnt  = (t == 1 + g) && (g <= last);
            rv   = is_ld && !fault && (t == 2 + g + r);
            drive(ins, a, wd, hold, gnt, rv, rd);
            e_req   = t >= 1 && t <= 1 + ((g < last) ? g : last);
            e_stall = t < done_t;
            e_rv    = t >= done_t && t < total && is_ld && !fault;
            e_ex    = (t >= done_t && t < total && fault) ? 4'b0010 : 4'b0;
            chk({tag, ".req"},   {31'h0, dmem_req}, {31'h0, e_req});
            chk({tag, ".stall"}, {31'h0, lsu_stall}, {31'h0, e_stall});
            chk({tag, ".rv"},    {31'h0, lsu_rvalid}, {31'h0, e_rv});
            chk({tag, ".exc"},   {28'h0, exv()}, {28'h0, e_ex});
            if (e_rv)
                chk({tag, ".rdata"}, lsu_rdata, ld_ref(f3, a, rd));
            if (e_ex != 4'h0) begin
                chk({tag, ".tval"},  exc_tval, a);
                chk({tag, ".frd"},   lsu_rdata, 32'h0);
            end
            if (t == 1) begin
                chk({tag, ".addr"}, dmem_addr, {a[31:2], 2'b00});
                chk({tag, ".we"},   {31'h0, dmem_we}, {31'h0, is_st});
                if (is_st || f3 == 3'd2)
                    chk({tag, ".be"}, {28'h0, dmem_be},
                        {28'h0, be_ref(f3, a)});
                if (is_st)
                    chk({tag, ".wd"}, dmem_wdata, wd_ref(f3, wd));
            end
        end
    endtask

    task automatic run_reset_mid();
        logic [31:0] ins;
        ins = mk(LD, 3'd2);
        drive(ins, 32'h500, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        drive(ins, 32'h500, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        drive(ins, 32'h500, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("rmid.inwait", {31'h0, lsu_stall}, 32'h1);
        reset = 1'b0;
        drive(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        reset = 1'b1;
        chk_zero("rmid");
        drive(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hCAFEF00D);
        chk_zero("rmid.rsp");
        drive(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("rmid.rv", {31'h0, lsu_rvalid}, 32'h0);
    endtask

    initial begin
        logic [6:0]  op;
        logic [31:0] a;
        reset       = 1'b0;
        inst_i      = 32'h0;
        addr_i      = 32'h0;
        wdata_i     = 32'h0;
        pipe_hold_i = 1'b0;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'h0;
        drive(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        drive(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk_zero("reset");
        reset = 1'b1;

        run_op("lw",   mk(LD, 3'd2), 32'h100, 0, 32'hDEADBEEF, 0, 0, 0);
        run_op("lb3",  mk(LD, 3'd0), 32'h103, 0, 32'h80FF7F01, 0, 0, 0);
        run_op("lbu3", mk(LD, 3'd4), 32'h103, 0, 32'h80FF7F01, 1, 0, 0);
        run_op("lh2",  mk(LD, 3'd1), 32'h102, 0, 32'h80FF7F01, 0, 1, 0);
        run_op("lhu0", mk(LD, 3'd5), 32'h100, 0, 32'h80FF7F01, 0, 0, 0);
        run_op("sb",   mk(ST, 3'd0), 32'h203, 32'hAB, 0, 0, 0, 0);
        run_op("sh",   mk(ST, 3'd1), 32'h202, 32'h1234, 0, 0, 0, 0);
        run_op("lwmis", mk(LD, 3'd2), 32'h102, 0, 0, 0, 0, 0);
        run_op("shmis", mk(ST, 3'd1), 32'h101, 0, 0, 0, 0, 0);
        run_op("ill",   mk(LD, 3'd3), 32'h104, 0, 0, 0, 0, 0);
        run_op("tmo",   mk(LD, 3'd2), 32'h300, 0, 0, 100, 0, 0);
        run_op("tmow",  mk(LD, 3'd0), 32'h301, 0, 0, 1, 100, 0);
        run_op("hold",  mk(LD, 3'd2), 32'h400, 0, 32'h12345678, 0, 0, 2);
        run_reset_mid();

        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 9))
                0:       op = AL;
                1, 2, 3: op = ST;
                default: op = LD;
            endcase
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            if ($urandom_range(0, 15) == 0)
                run_op("bub", 32'h0, a, $urandom, $urandom, 0, 0, 0);
            else
                run_op("rnd", mk(op, 3'($urandom_range(0, 7))), a,
                       $urandom, $urandom, $urandom_range(0, 3),
                       $urandom_range(0, 3), $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
